// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path.
// Holds the default byte width and the address-width helper used to size
// FIFO pointers from the entry count.
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    // Smallest r with 2**r >= n; gives ADDR_W for a power-of-two depth.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte/read/status bundle between the UART receive FIFO and its neighbours.
//   master : the UART receiver plus the consumer (drives P_DATA, data_valid,
//            RD_EN, CLR_OVF; observes read data and status)
//   slave  : the FIFO itself
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = log2_ceil(DEPTH) + 1;

    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              RD_EN;
    logic              CLR_OVF;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic              EMPTY;
    logic              FULL;
    logic              ALMOST_FULL;
    logic [CNT_W-1:0]  COUNT;
    logic              OVERFLOW;

    modport master (
        output P_DATA, data_valid, RD_EN, CLR_OVF,
        input  RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW
    );

    modport slave (
        input  P_DATA, data_valid, RD_EN, CLR_OVF,
        output RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W storage for the receive FIFO.
//   clk                       : write clock
//   wr_en, wr_addr, wr_data   : synchronous write port
//   rd_addr -> rd_data        : asynchronous read port
// Contents are intentionally not reset.
module uart_rx_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO sitting directly behind the UART receiver.
//   CLK, RST : system clock, asynchronous active-high reset
//   bus      : slave side of uart_rx_fifo_if
//              in : P_DATA, data_valid (write pulse), RD_EN, CLR_OVF
//              out: RD_DATA/RD_VALID (registered read return), EMPTY, FULL,
//                   ALMOST_FULL, COUNT, OVERFLOW (sticky drop flag)
// Bytes arriving while full are dropped and flagged; there is no bypass
// from write to read when empty.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_fifo_if.slave  bus
);

    localparam int unsigned ADDR_W = log2_ceil(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [PTR_W-1:0]  count_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic              drop;
    logic [DATA_W-1:0] mem_rd_data;

    // Acceptance uses the registered flags, i.e. the state before this edge.
    always_comb begin
        wr_acc     = bus.data_valid & ~bus.FULL;
        rd_acc     = bus.RD_EN & ~bus.EMPTY;
        drop       = bus.data_valid & bus.FULL;
        wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);
        rd_ptr_nxt = rd_ptr + PTR_W'(rd_acc);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    uart_rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (bus.P_DATA),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (mem_rd_data)
    );

    // Pointers and status flags; flags are registered from the next pointers
    // so they change on the same edge as the pointers themselves.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            bus.COUNT       <= '0;
            bus.EMPTY       <= 1'b1;
            bus.FULL        <= 1'b0;
            bus.ALMOST_FULL <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_nxt;
            rd_ptr          <= rd_ptr_nxt;
            bus.COUNT       <= count_nxt;
            bus.EMPTY       <= (wr_ptr_nxt == rd_ptr_nxt);
            bus.FULL        <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                               (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
            bus.ALMOST_FULL <= (count_nxt >= PTR_W'(AF_LEVEL));
        end
    end

    // Registered read return; RD_DATA holds between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.RD_VALID <= 1'b0;
            bus.RD_DATA  <= '0;
        end else begin
            bus.RD_VALID <= rd_acc;
            if (rd_acc) begin
                bus.RD_DATA <= mem_rd_data;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.OVERFLOW <= 1'b0;
        end else if (drop) begin
            bus.OVERFLOW <= 1'b1;
        end else if (bus.CLR_OVF) begin
            bus.OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFL   = 6;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    logic m_ovf;

    logic [7:0] model_q [$];
    exp_t       exp_q   [$];

    uart_rx_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every read return is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.RD_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: RD_VALID with data 0x%0h, none expected", bus.RD_DATA);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", 32'(bus.RD_DATA), 32'(e.data));
                chk("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, ".COUNT"}, 32'(bus.COUNT), 32'(model_q.size()));
        chk({tag, ".EMPTY"}, 32'(bus.EMPTY), 32'(model_q.size() == 0));
        chk({tag, ".FULL"}, 32'(bus.FULL), 32'(model_q.size() == DEPTH));
        chk({tag, ".ALMOST_FULL"}, 32'(bus.ALMOST_FULL), 32'(model_q.size() >= AFL));
        chk({tag, ".OVERFLOW"}, 32'(bus.OVERFLOW), 32'(m_ovf));
    endtask

    // One clock of stimulus; called at #1 after an active edge.
    task automatic step(input string tag, input logic wv, input logic [7:0] d,
                        input logic rv, input logic clr);
        logic was_full;
        logic had_data;
        bus.data_valid = wv;
        bus.P_DATA     = d;
        bus.RD_EN      = rv;
        bus.CLR_OVF    = clr;
        was_full = (model_q.size() == DEPTH);
        had_data = (model_q.size() != 0);
        if (rv && had_data) begin
            exp_t e;
            e.data = model_q.pop_front();
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        if (wv && !was_full) model_q.push_back(d);
        if (wv && was_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic idle();
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".EMPTY"}, 32'(bus.EMPTY), 32'd1);
        chk({tag, ".FULL"}, 32'(bus.FULL), 32'd0);
        chk({tag, ".ALMOST_FULL"}, 32'(bus.ALMOST_FULL), 32'd0);
        chk({tag, ".COUNT"}, 32'(bus.COUNT), 32'd0);
        chk({tag, ".OVERFLOW"}, 32'(bus.OVERFLOW), 32'd0);
        chk({tag, ".RD_VALID"}, 32'(bus.RD_VALID), 32'd0);
        chk({tag, ".RD_DATA"}, 32'(bus.RD_DATA), 32'h00);
    endtask

    initial begin
        logic [7:0] order_v [3];
        errors = 0;
        checks = 0;
        cyc    = 0;
        m_ovf  = 1'b0;
        rst    = 1'b1;
        bus.data_valid = 1'b0;
        bus.P_DATA     = '0;
        bus.RD_EN      = 1'b0;
        bus.CLR_OVF    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Ordering with idle gaps
        order_v = '{8'hA5, 8'h3C, 8'hF0};
        for (int i = 0; i < 3; i++) begin
            step("ord_wr", 1'b1, order_v[i], 1'b0, 1'b0);
            idle();
        end
        chk("ord_count3", 32'(bus.COUNT), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step("ord_rd", 1'b0, 8'h00, 1'b1, 1'b0);
            idle();
        end
        chk("ord_empty_end", 32'(bus.EMPTY), 32'd1);

        // Fill, overflow, drain, clear
        for (int i = 0; i < 8; i++) begin
            step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_af_hand", 32'(bus.ALMOST_FULL), 32'(i >= 5));
        end
        chk("fill_full", 32'(bus.FULL), 32'd1);
        step("ovf_wr_ee", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.OVERFLOW), 32'd1);
        chk("ovf_count8", 32'(bus.COUNT), 32'd8);
        step("ovf_drop_and_clr", 1'b1, 8'hEF, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(bus.OVERFLOW), 32'd1);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(bus.OVERFLOW), 32'd0);
        idle();

        // Simultaneous write and read while full
        for (int i = 0; i < 8; i++) step("fill2", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'h99, 1'b1, 1'b0);
        chk("full_wr_rd_count7", 32'(bus.COUNT), 32'd7);
        chk("full_wr_rd_ovf", 32'(bus.OVERFLOW), 32'd1);
        for (int i = 0; i < 4; i++) step("to3", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Wrap-around with interleaved write/read at COUNT = 3
        for (int i = 0; i < 20; i++) begin
            step("wrap", 1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
            chk("wrap_count3", 32'(bus.COUNT), 32'd3);
        end
        for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // Reset mid-stream with RD_EN held
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step("pre_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_q.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_no_rd_valid", 32'(bus.RD_VALID), 32'd0);

        // Write and read together while empty: write only, no bypass
        step("empty_wr_rd", 1'b1, 8'hC3, 1'b1, 1'b0);
        chk("empty_wr_rd_no_valid", 32'(bus.RD_VALID), 32'd0);
        chk("empty_wr_rd_count1", 32'(bus.COUNT), 32'd1);
        step("empty_follow_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        idle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
